// File: rtl/sa_output_deskew_4x4.sv
// rtl/sa_output_deskew_4x4.sv - realigns skewed 4x4 SA result lanes, saturates to 16 bits, buffers a tile, drains it as a stream
// Optional DESKEW_RELU_EN: negative lanes clamp to 0 before saturation.
module sa_output_deskew_4x4 #(
  parameter int ACC_W   = 32,
  parameter int NUM_VEC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [ACC_W-1:0] in1,
  input  logic [ACC_W-1:0] in2,
  input  logic [ACC_W-1:0] in3,
  input  logic [ACC_W-1:0] in4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [7:0]       out_idx,
  output logic [1:0]       out_lane,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [7:0] LAST_VEC = 8'(NUM_VEC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  function automatic logic [15:0] sat16(input logic [ACC_W-1:0] raw);
    logic signed [ACC_W-1:0] v;
    v = $signed(raw);
`ifdef DESKEW_RELU_EN
    if (v[ACC_W-1]) v = '0;
`endif
    if (v > SAT_MAX) return 16'h7fff;
    else if (v < SAT_MIN) return 16'h8000;
    else return v[15:0];
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] d1_q [3];
  logic [ACC_W-1:0] d1_d [3];
  logic [ACC_W-1:0] d2_q [2];
  logic [ACC_W-1:0] d2_d [2];
  logic [ACC_W-1:0] d3_q, d3_d;
  logic [2:0]       vld_q, vld_d;
  logic [7:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]       rd_vec_q, rd_vec_d;
  logic [1:0]       rd_lane_q, rd_lane_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             vld_a;
  logic             wr_en;
  logic [15:0]      wr_vec [4];
  logic [15:0]      mem_q [NUM_VEC][4];

  assign vld_a = vld_q[2];

  always_comb begin
    d1_d[0]     = in1;
    d1_d[1]     = d1_q[0];
    d1_d[2]     = d1_q[1];
    d2_d[0]     = in2;
    d2_d[1]     = d2_q[0];
    d3_d        = in3;
    vld_d       = {vld_q[1:0], vld_in};
    wr_vec[0]   = sat16(d1_q[2]);
    wr_vec[1]   = sat16(d2_q[1]);
    wr_vec[2]   = sat16(d3_q);
    wr_vec[3]   = sat16(in4);
    wr_en       = 1'b0;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_vec_d    = rd_vec_q;
    rd_lane_d   = rd_lane_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (vld_in) state_d = COLLECT;
      end
      COLLECT: begin
        if (vld_a) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_VEC) begin
            state_d  = DRAIN;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (vld_in || vld_a) ovf_d = 1'b1;
        // First drain cycle only loads the head element; later ones advance on handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_vec_q[VW-1:0]][rd_lane_q];
        end else if (out_ready) begin
          if (rd_vec_q == LAST_VEC && rd_lane_q == 2'd3) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            rd_vec_d    = '0;
            rd_lane_d   = '0;
            done_d      = 1'b1;
          end else begin
            rd_lane_d  = rd_lane_q + 2'd1;
            rd_vec_d   = (rd_lane_q == 2'd3) ? rd_vec_q + 8'd1 : rd_vec_q;
            out_data_d = mem_q[rd_vec_d[VW-1:0]][rd_lane_d];
          end
        end
      end
      DONE: begin
        if (vld_in || vld_a) ovf_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d1_q        <= '{default: '0};
      d2_q        <= '{default: '0};
      d3_q        <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_vec_q    <= '0;
      rd_lane_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_vec_q    <= rd_vec_d;
      rd_lane_q   <= rd_lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  // Tile storage survives reset; a fresh tile always overwrites from slot 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[VW-1:0]] <= wr_vec;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = rd_vec_q;
  assign out_lane  = rd_lane_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_sa_output_deskew_4x4.sv
// tb/tb_sa_output_deskew_4x4.sv - scoreboard bench for sa_output_deskew_4x4 (NUM_VEC=2 and NUM_VEC=16 instances)
module tb_sa_output_deskew_4x4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld2 = 1'b0, vld16 = 1'b0;
  logic [31:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic        rdy2 = 1'b0, rdy16 = 1'b0;
  logic        ov2, ov16, busy2, busy16, done2, done16, ovf2, ovf16;
  logic [15:0] od2, od16;
  logic [7:0]  oi2, oi16;
  logic [1:0]  ol2, ol16;

  always #5 clk = ~clk;

  sa_output_deskew_4x4 #(.ACC_W(32), .NUM_VEC(2)) u2 (
    .clk(clk), .rst(rst), .vld_in(vld2), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out_valid(ov2), .out_ready(rdy2), .out_data(od2), .out_idx(oi2), .out_lane(ol2),
    .busy(busy2), .done(done2), .ovf(ovf2));

  sa_output_deskew_4x4 #(.ACC_W(32), .NUM_VEC(16)) u16 (
    .clk(clk), .rst(rst), .vld_in(vld16), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out_valid(ov16), .out_ready(rdy16), .out_data(od16), .out_idx(oi16), .out_lane(ol16),
    .busy(busy16), .done(done16), .ovf(ovf16));

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  idx;
    logic [1:0]  lane;
  } elem_t;

  elem_t q2[$];
  elem_t q16[$];
  int    checks = 0, failures = 0;
  int    done_cnt2 = 0, done_cnt16 = 0;
  int    raw [16][4];
  int    expv [16][4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic chk_elem(input string nm, input elem_t act, input elem_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got data=%0d idx=%0d lane=%0d expected data=%0d idx=%0d lane=%0d",
               nm, $signed(act.d), act.idx, act.lane, $signed(exp.d), exp.idx, exp.lane);
    end
  endtask

  task automatic chk_hold(input string nm, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {valid,data,idx,lane}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    elem_t e, h2, h16;
    logic  st2, st16;
    st2 = 1'b0;
    st16 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st2 = 1'b0;
        st16 = 1'b0;
      end else begin
        if (st2) chk_hold("u2_stall_hold", {ov2, od2, oi2, ol2}, {1'b1, h2});
        st2 = ov2 && !rdy2;
        h2 = '{od2, oi2, ol2};
        if (ov2 && rdy2) begin
          if (q2.size() == 0) begin
            checks++; failures++;
            $display("FAIL u2_extra_elem: got data=%0d idx=%0d with nothing expected", $signed(od2), oi2);
          end else begin
            e = q2.pop_front();
            chk_elem("u2_elem", '{od2, oi2, ol2}, e);
          end
        end
        if (done2) done_cnt2++;
        if (st16) chk_hold("u16_stall_hold", {ov16, od16, oi16, ol16}, {1'b1, h16});
        st16 = ov16 && !rdy16;
        h16 = '{od16, oi16, ol16};
        if (ov16 && rdy16) begin
          if (q16.size() == 0) begin
            checks++; failures++;
            $display("FAIL u16_extra_elem: got data=%0d idx=%0d with nothing expected", $signed(od16), oi16);
          end else begin
            e = q16.pop_front();
            chk_elem("u16_elem", '{od16, oi16, ol16}, e);
          end
        end
        if (done16) done_cnt16++;
      end
    end
  endtask

  task automatic set_vec(input int v, input int r0, input int r1, input int r2, input int r3,
                         input int e0, input int e1, input int e2, input int e3);
    raw[v][0] = r0; raw[v][1] = r1; raw[v][2] = r2; raw[v][3] = r3;
    expv[v][0] = e0; expv[v][1] = e1; expv[v][2] = e2; expv[v][3] = e3;
  endtask

  // Drives n vectors with the SA skew: lane k of vector c appears k-1 cycles after vld.
  task automatic send(input int sel, input int n, input bit push);
    elem_t e;
    if (push) begin
      for (int v = 0; v < n; v++) begin
        for (int l = 0; l < 4; l++) begin
          e = '{16'(expv[v][l]), 8'(v), 2'(l)};
          if (sel == 0) q2.push_back(e);
          else q16.push_back(e);
        end
      end
    end
    for (int c = 0; c < n + 3; c++) begin
      @(posedge clk); #1;
      if (sel == 0) vld2 = (c < n);
      else vld16 = (c < n);
      in1 = (c < n) ? raw[c][0] : 0;
      in2 = (c >= 1 && c - 1 < n) ? raw[c-1][1] : 0;
      in3 = (c >= 2 && c - 2 < n) ? raw[c-2][2] : 0;
      in4 = (c >= 3 && c - 3 < n) ? raw[c-3][3] : 0;
    end
    @(posedge clk); #1;
    vld2 = 1'b0; vld16 = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
  endtask

  task automatic wait_done(input int sel, input bit bp, input string nm);
    int start, k, now;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    start = (sel == 0) ? done_cnt2 : done_cnt16;
    k = 0;
    now = start;
    while (now == start && k < 400) begin
      @(posedge clk); #1;
      if (sel == 0) rdy2 = bp ? pat[k % 4] : 1'b1;
      else rdy16 = bp ? pat[k % 4] : 1'b1;
      now = (sel == 0) ? done_cnt2 : done_cnt16;
      k++;
    end
    if (now == start) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no done pulse within %0d cycles expected one", nm, k);
    end
    if (sel == 0) rdy2 = 1'b1;
    else rdy16 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, (sel == 0) ? done_cnt2 - start : done_cnt16 - start, 1);
    chk({nm, "_queue_empty"}, (sel == 0) ? q2.size() : q16.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, k;
    logic b0, b1;
    fork
      monitor();
    join_none

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid2", ov2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_ovf2", ovf2, 0);
    chk("rst_out_data2", od2, 0);
    chk("rst_out_valid16", ov16, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_idx_lane16", {oi16, ol16}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic alignment, ordering and done pulse.
    set_vec(0, 1, 3, 5, 7, 1, 3, 5, 7);
    set_vec(1, 2, 4, 6, 8, 2, 4, 6, 8);
    rdy2 = 1'b1;
    send(0, 2, 1);
    wait_done(0, 0, "t1");
    chk("t1_busy_after", busy2, 0);

    // Saturation.
`ifdef DESKEW_RELU_EN
    set_vec(0, 40000, -70000, -5, 32767, 32767, 0, 0, 32767);
    set_vec(1, 100, -100, 0, -32768, 100, 0, 0, 0);
`else
    set_vec(0, 40000, -70000, -5, 32767, 32767, -32768, -5, 32767);
    set_vec(1, 100, -100, 0, -32768, 100, -100, 0, -32768);
`endif
    send(0, 2, 1);
    wait_done(0, 0, "t2");

    // Backpressure with ready pattern 1,0,0,1.
    set_vec(0, 10, 11, 12, 13, 10, 11, 12, 13);
    set_vec(1, 20, 21, 22, 23, 20, 21, 22, 23);
    send(0, 2, 1);
    wait_done(0, 1, "t3");

    // Overflow: vld_in while draining.
    set_vec(0, 30, 31, 32, 33, 30, 31, 32, 33);
    set_vec(1, 40, 41, 42, 43, 40, 41, 42, 43);
    rdy2 = 1'b0;
    send(0, 2, 1);
    k = 0;
    while (!ov2 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t4_drain_reached", ov2, 1);
    chk("t4_ovf_before", ovf2, 0);
    vld2 = 1'b1; in1 = 999; in2 = 999; in3 = 999; in4 = 999;
    @(posedge clk); #1;
    vld2 = 1'b0; in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    @(negedge clk);
    chk("t4_ovf_set", ovf2, 1);
    wait_done(0, 0, "t4");
    chk("t4_ovf_sticky", ovf2, 1);

    // Reset in the middle of a 16-vector tile.
    for (int v = 0; v < 16; v++)
      set_vec(v, (v + 1) * 100, -(v * 50 + 1), v * 3, 20000 - v,
              (v + 1) * 100, -(v * 50 + 1), v * 3, 20000 - v);
    rdy16 = 1'b1;
    send(1, 5, 0);
    chk("t5_busy_before_rst", busy16, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy16", busy16, 0);
    chk("t5_rst_valid16", ov16, 0);
    chk("t5_rst_done16", done16, 0);
    chk("t5_rst_ovf2", ovf2, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-rate tile after the reset: first element at cycle 20, 64 elements.
    cyc = -1;
    b0 = 1'bx;
    b1 = 1'bx;
    fork
      send(1, 16, 1);
      begin
        @(posedge clk);
        for (int j = 0; j < 100; j++) begin
          @(negedge clk);
          if (j == 0) b0 = busy16;
          if (j == 1) b1 = busy16;
          if (ov16) begin
            cyc = j;
            break;
          end
        end
      end
    join
    chk("t6_busy_cycle0", b0, 0);
    chk("t6_busy_cycle1", b1, 1);
    chk("t6_first_valid_cycle", cyc, 20);
    wait_done(1, 0, "t6");
    chk("t6_ovf16", ovf16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
